arb_credit_ctrl: RTL and testbench

- Initiator/consumer side of the arb counter interface.
- Drives the counter's increment, decrement and clear controls, and consumes its count and overflow status, to implement credit-based flow control for the 8b10b link transmit path.
- Gates flits from the upstream arbiter into the encoder: it grants a flit only while credits remain, and replenishes credits on credit-return strobes from the link receiver.

---
 rtl/arb_credit_ctrl.sv | 169 ++++++++++++++++
 tb/tb_arb_credit_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_credit_ctrl.sv
// Credit-based flow-control initiator driving an up/down credit counter for the 8b10b transmit path.
// Optional low-credit watermark output: define ARB_CREDIT_WATERMARK_EN.
module arb_credit_ctrl #(
  parameter int NBITS        = 4,
  parameter int INIT_CREDITS = 8
`ifdef ARB_CREDIT_WATERMARK_EN
  ,
  parameter int LOW_WM       = 2
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             credit_return,
  output logic             cnt_en,
  output logic             cnt_dec,
  output logic             cnt_clear,
  input  logic [NBITS-1:0] cnt_count,
  input  logic             cnt_overflow,
  output logic             init_done,
  output logic             err
`ifdef ARB_CREDIT_WATERMARK_EN
  ,
  output logic             credit_low
`endif
);

  typedef enum logic [1:0] {
    ST_CLR    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [NBITS-1:0] ZERO_C      = {NBITS{1'b0}};
  localparam logic [NBITS-1:0] ONE_C       = NBITS'(1);
  localparam logic [NBITS-1:0] FULL_C      = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] LOAD_LAST_C = NBITS'(INIT_CREDITS - 1);

  state_t           state_r;
  logic [NBITS-1:0] load_cnt_r;
  logic             load_en_r;
  logic             clear_r;
  logic             init_done_r;
  logic             err_r;

  logic             tx_ready_s;
  logic             send_only_s;
  logic             ret_only_s;
  logic             active_en_s;
  logic             full_s;

  // Grant and counter-step decode while credits are live.
  always_comb begin
    tx_ready_s  = 1'b0;
    send_only_s = 1'b0;
    ret_only_s  = 1'b0;
    active_en_s = 1'b0;
    full_s      = (cnt_count == FULL_C);
    if (state_r == ST_ACTIVE) begin
      tx_ready_s  = tx_valid && (cnt_count != ZERO_C);
      send_only_s = tx_ready_s && !credit_return;
      ret_only_s  = credit_return && !tx_ready_s;
      // A return at full count is suppressed so the counter never wraps.
      active_en_s = send_only_s || (ret_only_s && !full_s);
    end else begin
      tx_ready_s  = 1'b0;
      send_only_s = 1'b0;
      ret_only_s  = 1'b0;
      active_en_s = 1'b0;
    end
  end

  // Control FSM: one clear cycle, INIT_CREDITS increments, then live; errors are sticky until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_CLR;
      load_cnt_r  <= ZERO_C;
      load_en_r   <= 1'b0;
      clear_r     <= 1'b0;
      init_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_CLR: begin
          if (credit_return) begin
            state_r     <= ST_ERR;
            err_r       <= 1'b1;
            clear_r     <= 1'b1;
            load_en_r   <= 1'b0;
            init_done_r <= 1'b0;
          end else if (!clear_r) begin
            clear_r <= 1'b1;
          end else begin
            clear_r    <= 1'b0;
            load_en_r  <= 1'b1;
            load_cnt_r <= ZERO_C;
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (credit_return || cnt_overflow) begin
            state_r     <= ST_ERR;
            err_r       <= 1'b1;
            clear_r     <= 1'b1;
            load_en_r   <= 1'b0;
            init_done_r <= 1'b0;
          end else if (load_cnt_r == LOAD_LAST_C) begin
            load_en_r   <= 1'b0;
            init_done_r <= 1'b1;
            state_r     <= ST_ACTIVE;
          end else begin
            load_cnt_r <= load_cnt_r + ONE_C;
          end
        end
        ST_ACTIVE: begin
          if (cnt_overflow || (ret_only_s && full_s)) begin
            state_r     <= ST_ERR;
            err_r       <= 1'b1;
            clear_r     <= 1'b1;
            load_en_r   <= 1'b0;
            init_done_r <= 1'b0;
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        ST_ERR: begin
          state_r     <= ST_ERR;
          err_r       <= 1'b1;
          clear_r     <= 1'b1;
          load_en_r   <= 1'b0;
          init_done_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_ERR;
          err_r       <= 1'b1;
          clear_r     <= 1'b1;
          load_en_r   <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = tx_ready_s;
  assign cnt_en    = load_en_r | active_en_s;
  assign cnt_dec   = send_only_s;
  assign cnt_clear = clear_r;
  assign init_done = init_done_r;
  assign err       = err_r;

`ifdef ARB_CREDIT_WATERMARK_EN
  localparam logic [NBITS-1:0] LOW_WM_C = NBITS'(LOW_WM);
  logic credit_low_r;

  // Early low-credit hint for the upstream arbiter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      credit_low_r <= 1'b0;
    end else begin
      credit_low_r <= init_done_r && (cnt_count <= LOW_WM_C);
    end
  end

  assign credit_low = credit_low_r;
`endif

endmodule

// File: tb/tb_arb_credit_ctrl.sv
// Directed bench for arb_credit_ctrl with a behavioural up/down credit counter attached.
module tb_arb_credit_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tx_valid = 1'b0;
  logic       credit_return = 1'b0;
  logic       force_ovf = 1'b0;
  logic       tx_ready, cnt_en, cnt_dec, cnt_clear, init_done, err;
  logic [3:0] m_cnt = 4'd0;
  logic       m_ovf = 1'b0;
  logic [3:0] cnt_count;
  logic       cnt_overflow;
`ifdef ARB_CREDIT_WATERMARK_EN
  logic       credit_low;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  arb_credit_ctrl #(
    .NBITS(4),
    .INIT_CREDITS(8)
`ifdef ARB_CREDIT_WATERMARK_EN
    , .LOW_WM(2)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .credit_return(credit_return), .cnt_en(cnt_en), .cnt_dec(cnt_dec),
    .cnt_clear(cnt_clear), .cnt_count(cnt_count), .cnt_overflow(cnt_overflow),
    .init_done(init_done), .err(err)
`ifdef ARB_CREDIT_WATERMARK_EN
    , .credit_low(credit_low)
`endif
  );

  // Counter the controller drives: clear has priority, otherwise step on enable.
  always @(posedge CLK) begin
    if (cnt_clear) begin
      m_cnt <= 4'd0;
      m_ovf <= 1'b0;
    end else if (cnt_en) begin
      if (cnt_dec) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd0) m_ovf <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 4'd1;
        if (m_cnt == 4'hF) m_ovf <= 1'b1;
      end
    end
  end

  assign cnt_count    = m_cnt;
  assign cnt_overflow = m_ovf | force_ovf;

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  // Observes a reload after reset release; the callers judge the results.
  task automatic wait_init(output int clr_cycles, output int pulses, output int dec_pulses, output bit timed_out);
    clr_cycles = 0; pulses = 0; dec_pulses = 0; timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cnt_clear) clr_cycles++;
      if (cnt_en) begin
        pulses++;
        if (cnt_dec) dec_pulses++;
      end
      if (init_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int clr, pul, dec;
    bit to;
    RST = 1'b1;
    repeat (2) tick();
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
    n_checks++; if (cnt_dec !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_dec: got %b want 0", cnt_dec); end
    n_checks++; if (cnt_clear !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_clear: got %b want 0", cnt_clear); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    RST = 1'b0;
    wait_init(clr, pul, dec, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL init_timeout: init_done never rose"); end
    n_checks++; if (clr != 1) begin n_fail++; $display("FAIL init_clear_cycles: got %0d want 1", clr); end
    n_checks++; if (pul != 8) begin n_fail++; $display("FAIL init_pulses: got %0d want 8", pul); end
    n_checks++; if (dec != 0) begin n_fail++; $display("FAIL init_dec_pulses: got %0d want 0", dec); end
    n_checks++; if (cnt_count !== 4'd8) begin n_fail++; $display("FAIL init_count: got %0d want 8", cnt_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %b want 0", err); end
  endtask

  task automatic test_drain;
    logic exp_rdy;
    logic [3:0] exp_cnt;
    tx_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_rdy = (i < 8) ? 1'b1 : 1'b0;
      exp_cnt = (i < 8) ? 4'(8 - i) : 4'd0;
      n_checks++; if (tx_ready !== exp_rdy) begin n_fail++; $display("FAIL drain_tx_ready[%0d]: got %b want %b", i, tx_ready, exp_rdy); end
      n_checks++; if (cnt_en !== exp_rdy) begin n_fail++; $display("FAIL drain_cnt_en[%0d]: got %b want %b", i, cnt_en, exp_rdy); end
      n_checks++; if (cnt_dec !== exp_rdy) begin n_fail++; $display("FAIL drain_cnt_dec[%0d]: got %b want %b", i, cnt_dec, exp_rdy); end
      n_checks++; if (cnt_count !== exp_cnt) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, cnt_count, exp_cnt); end
`ifdef ARB_CREDIT_WATERMARK_EN
      n_checks++; if (credit_low !== ((i >= 7) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL drain_credit_low[%0d]: got %b want %b", i, credit_low, (i >= 7)); end
`endif
      tick();
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_refill;
    credit_return = 1'b1;
    #1;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL refill_ready_at_zero: got %b want 0", tx_ready); end
    n_checks++; if (cnt_en !== 1'b1 || cnt_dec !== 1'b0) begin n_fail++; $display("FAIL refill_inc: got en=%b dec=%b want en=1 dec=0", cnt_en, cnt_dec); end
    tick();
    credit_return = 1'b0;
    tx_valid = 1'b1;
    #1;
    n_checks++; if (cnt_count !== 4'd1) begin n_fail++; $display("FAIL refill_count: got %0d want 1", cnt_count); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready: got %b want 1", tx_ready); end
    tick();
    n_checks++; if (cnt_count !== 4'd0) begin n_fail++; $display("FAIL refill_count_after: got %0d want 0", cnt_count); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL refill_ready_after: got %b want 0", tx_ready); end
    tx_valid = 1'b0;
  endtask

  task automatic test_simultaneous;
    credit_return = 1'b1;
    repeat (3) tick();
    credit_return = 1'b0;
    #1;
    n_checks++; if (cnt_count !== 4'd3) begin n_fail++; $display("FAIL simul_setup_count: got %0d want 3", cnt_count); end
    tx_valid = 1'b1;
    credit_return = 1'b1;
    #1;
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL simul_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL simul_cnt_en: got %b want 0", cnt_en); end
    tick();
    tx_valid = 1'b0;
    credit_return = 1'b0;
    #1;
    n_checks++; if (cnt_count !== 4'd3) begin n_fail++; $display("FAIL simul_count: got %0d want 3", cnt_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL simul_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_drain;
    int clr, pul, dec;
    bit to;
    credit_return = 1'b1;
    repeat (5) tick();
    credit_return = 1'b0;
    #1;
    n_checks++; if (cnt_count !== 4'd8) begin n_fail++; $display("FAIL mid_setup_count: got %0d want 8", cnt_count); end
    tx_valid = 1'b1;
    repeat (3) tick();
    tx_valid = 1'b0;
    #1;
    n_checks++; if (cnt_count !== 4'd5) begin n_fail++; $display("FAIL mid_count_after_sends: got %0d want 5", cnt_count); end
    RST = 1'b1;
    tick();
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_init_done: got %b want 0", init_done); end
    n_checks++; if (cnt_en !== 1'b0 || cnt_clear !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got en=%b clr=%b want 0 0", cnt_en, cnt_clear); end
    RST = 1'b0;
    wait_init(clr, pul, dec, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL mid_reload_timeout: init_done never rose"); end
    n_checks++; if (clr != 1 || pul != 8 || dec != 0) begin n_fail++; $display("FAIL mid_reload_seq: got clr=%0d inc=%0d dec=%0d want 1 8 0", clr, pul, dec); end
    n_checks++; if (cnt_count !== 4'd8) begin n_fail++; $display("FAIL mid_reload_count: got %0d want 8", cnt_count); end
  endtask

  task automatic test_overfill;
    int clr, pul, dec;
    bit to;
    credit_return = 1'b1;
    repeat (7) tick();
    #1;
    n_checks++; if (cnt_count !== 4'd15) begin n_fail++; $display("FAIL overfill_count: got %0d want 15", cnt_count); end
    n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL overfill_suppress: got cnt_en=%b want 0", cnt_en); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL overfill_err_early: got %b want 0", err); end
    tick();
    credit_return = 1'b0;
    tx_valid = 1'b1;
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overfill_err: got %b want 1", err); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL overfill_tx_ready: got %b want 0", tx_ready); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL overfill_init_done: got %b want 0", init_done); end
    n_checks++; if (cnt_clear !== 1'b1 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL overfill_ctrl: got clr=%b en=%b want 1 0", cnt_clear, cnt_en); end
    repeat (3) tick();
    n_checks++; if (err !== 1'b1 || tx_ready !== 1'b0) begin n_fail++; $display("FAIL overfill_sticky: got err=%b rdy=%b want 1 0", err, tx_ready); end
    tx_valid = 1'b0;
    RST = 1'b1;
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL overfill_rst_err: got %b want 0", err); end
    RST = 1'b0;
    wait_init(clr, pul, dec, to);
    n_checks++; if (to !== 1'b0 || pul != 8) begin n_fail++; $display("FAIL overfill_reload: got timeout=%b inc=%0d want 0 8", to, pul); end
    n_checks++; if (cnt_count !== 4'd8) begin n_fail++; $display("FAIL overfill_reload_count: got %0d want 8", cnt_count); end
  endtask

  task automatic test_load_error;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    tick();
    n_checks++; if (cnt_en !== 1'b1 || cnt_dec !== 1'b0) begin n_fail++; $display("FAIL load_in_load: got en=%b dec=%b want 1 0", cnt_en, cnt_dec); end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL load_return_err: got %b want 1", err); end
    n_checks++; if (cnt_en !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL load_err_ctrl: got en=%b done=%b want 0 0", cnt_en, init_done); end
  endtask

  task automatic test_overflow_input;
    int clr, pul, dec;
    bit to;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wait_init(clr, pul, dec, to);
    n_checks++; if (to !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_setup: got timeout=%b err=%b want 0 0", to, err); end
    force_ovf = 1'b1;
    tick();
    force_ovf = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_refill();
    test_simultaneous();
    test_reset_mid_drain();
    test_overfill();
    test_load_error();
    test_overflow_input();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
